addsub_op_loader: RTL and testbench

//  Operand-entry sequencer directly upstream of the 5-bit adder/subtractor on the board.

---
 rtl/addsub_pkg.sv | 30 +++
 rtl/addsub_op_loader_btn_debounce.sv | 73 +++++++
 rtl/addsub_op_loader.sv | 176 +++++++++++++++++
 tb/tb_addsub_op_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the operand-entry sequencer in front of the
// 5-bit adder/subtractor.
//   ADDSUB_W       : operand/result width of the adder/subtractor
//   addsub_state_t : entry phases of the sequencer
//   phase_led      : maps an entry phase to the one-hot {OP,B,A} LED pattern
package addsub_pkg;

  localparam int ADDSUB_W = 5;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } addsub_state_t;

  // Only the three operand-entry phases light an LED; EXEC/DONE show 000.
  function automatic logic [2:0] phase_led(input addsub_state_t st);
    logic [2:0] led;
    case (st)
      LOAD_A:  led = 3'b001;
      LOAD_B:  led = 3'b010;
      LOAD_OP: led = 3'b100;
      default: led = 3'b000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/addsub_op_loader_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and
// rising-edge pulse generator.
//   clk       : system clock
//   rst       : asynchronous, active-high reset
//   btn_raw   : raw, bouncy, active-high button
//   btn_level : accepted (debounced) button level
//   btn_pulse : one-cycle pulse on each accepted rising edge
// A clean raw rise produces btn_pulse exactly DB_CYCLES+3 cycles later:
// two synchroniser stages, DB_CYCLES of stability, one edge-detect stage.
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  // Counter only needs to reach DB_CYCLES-1 before the level flips.
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             level_dly_q;
  logic             pulse_q;

  // Stability counter: counts consecutive cycles the synchronised level
  // differs from the accepted level; any agreement restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        cnt_d   = {CNT_W{1'b0}};
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Synchroniser, debounce state and registered edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pulse_q     <= level_q & ~level_dly_q;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/addsub_op_loader.sv
// Operand-entry sequencer for the 5-bit adder/subtractor.
// Loads A, B and the add/sub select from the slide switches, one debounced
// ENTER press per field, presents them (registered) to the external adder,
// then latches the adder's combinational S/Cout/Ov for the display stage.
//   clk, rst             : clock, asynchronous active-high reset
//   sw, sw_as            : raw operand switches, add(0)/sub(1) switch
//   btn_enter, btn_clear : raw bouncy push-buttons
//   op_a, op_b, op_as    : registered adder inputs
//   add_s/add_cout/add_ov: adder outputs (combinational, external)
//   res_s/res_cout/res_ov: latched result
//   res_valid            : one-cycle pulse while the result is being latched
//   res_ready            : high while a latched result is held (DONE)
//   state_led            : one-hot entry phase {OP,B,A}, 000 in EXEC/DONE
module addsub_op_loader
  import addsub_pkg::*;
#(
  parameter int WIDTH     = ADDSUB_W,
  parameter int DB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             sw_as,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_as,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  input  logic             add_ov,
  output logic [WIDTH-1:0] res_s,
  output logic             res_cout,
  output logic             res_ov,
  output logic             res_valid,
  output logic             res_ready,
  output logic [2:0]       state_led
);

  logic          ent_s;
  logic          clr_s;
  logic          ent_level_s;
  logic          clr_level_s;
  logic          unused_levels_s;

  addsub_state_t   state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             op_as_q;
  logic [WIDTH-1:0] res_s_q;
  logic             res_cout_q;
  logic             res_ov_q;
  logic             res_valid_q;
  logic             res_ready_q;
  logic [2:0]       state_led_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_enter),
    .btn_level (ent_level_s),
    .btn_pulse (ent_s)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_clear),
    .btn_level (clr_level_s),
    .btn_pulse (clr_s)
  );

  // Accepted button levels are not needed by the sequencer itself.
  assign unused_levels_s = ent_level_s ^ clr_level_s;

  // Entry sequencer: state, operand registers and result latch.
  // Outputs are registered alongside the state, so state_led is always
  // written with the LED pattern of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      op_a_q      <= {WIDTH{1'b0}};
      op_b_q      <= {WIDTH{1'b0}};
      op_as_q     <= 1'b0;
      res_s_q     <= {WIDTH{1'b0}};
      res_cout_q  <= 1'b0;
      res_ov_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_ready_q <= 1'b0;
      state_led_q <= 3'b000;
    end else begin
      res_valid_q <= 1'b0;
      if (clr_s) begin
        // Clear beats a coincident enter: the enter pulse is simply dropped.
        state_q     <= LOAD_A;
        state_led_q <= phase_led(LOAD_A);
        op_a_q      <= {WIDTH{1'b0}};
        op_b_q      <= {WIDTH{1'b0}};
        op_as_q     <= 1'b0;
        res_s_q     <= {WIDTH{1'b0}};
        res_cout_q  <= 1'b0;
        res_ov_q    <= 1'b0;
        res_ready_q <= 1'b0;
      end else begin
        case (state_q)
          LOAD_A: begin
            if (ent_s) begin
              op_a_q      <= sw;
              state_q     <= LOAD_B;
              state_led_q <= phase_led(LOAD_B);
            end else begin
              state_led_q <= phase_led(LOAD_A);
            end
          end
          LOAD_B: begin
            if (ent_s) begin
              op_b_q      <= sw;
              state_q     <= LOAD_OP;
              state_led_q <= phase_led(LOAD_OP);
            end else begin
              state_led_q <= phase_led(LOAD_B);
            end
          end
          LOAD_OP: begin
            if (ent_s) begin
              // res_valid is raised now so it is high during the EXEC cycle,
              // the same cycle the adder output is sampled.
              op_as_q     <= sw_as;
              state_q     <= EXEC;
              state_led_q <= phase_led(EXEC);
              res_valid_q <= 1'b1;
            end else begin
              state_led_q <= phase_led(LOAD_OP);
            end
          end
          EXEC: begin
            // op_* have been stable for the whole EXEC cycle.
            res_s_q     <= add_s;
            res_cout_q  <= add_cout;
            res_ov_q    <= add_ov;
            res_ready_q <= 1'b1;
            state_q     <= DONE;
            state_led_q <= phase_led(DONE);
          end
          DONE: begin
            if (ent_s) begin
              // Operands and result stay visible until overwritten.
              res_ready_q <= 1'b0;
              state_q     <= LOAD_A;
              state_led_q <= phase_led(LOAD_A);
            end else begin
              state_led_q <= phase_led(DONE);
            end
          end
          default: begin
            // Illegal encoding: restart the entry sequence.
            res_ready_q <= 1'b0;
            state_q     <= LOAD_A;
            state_led_q <= phase_led(LOAD_A);
          end
        endcase
      end
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_as     = op_as_q;
  assign res_s     = res_s_q;
  assign res_cout  = res_cout_q;
  assign res_ov    = res_ov_q;
  assign res_valid = res_valid_q;
  assign res_ready = res_ready_q;
  assign state_led = state_led_q;

endmodule

// File: tb/tb_addsub_op_loader.sv
// Directed bench for addsub_op_loader with DB_CYCLES = 4 and a behavioural
// 5-bit adder/subtractor wired to op_*/add_*. Expected results are queued
// when the final ENTER is driven and compared the cycle after res_valid.
module tb_addsub_op_loader;

  localparam int W  = 5;
  localparam int DB = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw;
  logic         sw_as;
  logic         btn_enter;
  logic         btn_clear;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_as;
  logic [W-1:0] add_s;
  logic         add_cout;
  logic         add_ov;
  logic [W-1:0] res_s;
  logic         res_cout;
  logic         res_ov;
  logic         res_valid;
  logic         res_ready;
  logic [2:0]   state_led;

  logic [W-1:0] b_eff;

  int   checks;
  int   errors;
  int   rv_count;
  int   rv_snap;
  int   led_changes;
  logic mon_pend;
  exp_t sb_q[$];
  exp_t e;

  addsub_op_loader #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .sw_as     (sw_as),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_as     (op_as),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .add_ov    (add_ov),
    .res_s     (res_s),
    .res_cout  (res_cout),
    .res_ov    (res_ov),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .state_led (state_led)
  );

  // Board adder/subtractor: A + (B ^ AS) + AS, Ov = signed overflow.
  assign b_eff = op_b ^ {W{op_as}};
  assign {add_cout, add_s} = {1'b0, op_a} + {1'b0, b_eff} + {5'd0, op_as};
  assign add_ov = (op_a[W-1] == b_eff[W-1]) && (add_s[W-1] != op_a[W-1]);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({op_a, op_b, op_as, res_s, res_cout, res_ov, res_valid, res_ready, state_led}), 32'd0);
  endtask

  // One clock: sample on the falling edge and run the result scoreboard.
  task automatic tick();
    @(negedge clk);
    if (mon_pend) begin
      mon_pend = 1'b0;
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_res_valid observed=1 expected=0");
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("res_s", 32'(res_s), 32'(e.s));
        chk("res_cout", 32'(res_cout), 32'(e.cout));
        chk("res_ov", 32'(res_ov), 32'(e.ov));
        chk("res_valid_one_cycle", 32'(res_valid), 32'd0);
        chk("res_ready_after", 32'(res_ready), 32'd1);
      end
    end
    if (res_valid === 1'b1) begin
      rv_count++;
      mon_pend = 1'b1;
      chk("exec_led", 32'(state_led), 32'd0);
    end
  endtask

  task automatic press(input logic ent, input logic clr_b, input int hold);
    btn_enter = ent;
    btn_clear = clr_b;
    repeat (hold) tick();
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    checks = 0; errors = 0; rv_count = 0; mon_pend = 1'b0;
    rst = 1'b1; sw = 5'd0; sw_as = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (3) tick();
    chk_zero("reset_state");
    rst = 1'b0;
    tick();
    chk("release_led", 32'(state_led), 32'd1);

    // Reset mid-LOAD_B discards the partial operand.
    sw = 5'd6;
    press(1'b1, 1'b0, 8);
    chk("t1_led_b", 32'(state_led), 32'd2);
    chk("t1_op_a", 32'(op_a), 32'd6);
    #1 rst = 1'b1;
    #1 chk_zero("t1_async_rst");
    tick();
    rst = 1'b0;
    tick();
    chk("t1_led_after", 32'(state_led), 32'd1);

    // 7 - 3 = 4, carry (no borrow), no overflow.
    sw = 5'd7;
    press(1'b1, 1'b0, 8);
    sw = 5'd31;
    repeat (5) tick();
    chk("t2_sw_ignored", 32'(op_a), 32'd7);
    sw = 5'd3;
    press(1'b1, 1'b0, 8);
    chk("t2_op_b", 32'(op_b), 32'd3);
    sw_as = 1'b1;
    sb_q.push_back('{s: 5'b00100, cout: 1'b1, ov: 1'b0});
    press(1'b1, 1'b0, 8);
    sw_as = 1'b0;
    chk("t2_op_as", 32'(op_as), 32'd1);
    chk("t2_ready", 32'(res_ready), 32'd1);
    chk("t2_done_led", 32'(state_led), 32'd0);

    // 15 + 1 = -16 signed: overflow, no carry.
    press(1'b1, 1'b0, 8);
    chk("t3_led_a", 32'(state_led), 32'd1);
    chk("t3_res_held", 32'(res_s), 32'd4);
    sw = 5'd15;
    press(1'b1, 1'b0, 8);
    sw = 5'd1;
    press(1'b1, 1'b0, 8);
    sb_q.push_back('{s: 5'b10000, cout: 1'b0, ov: 1'b1});
    press(1'b1, 1'b0, 8);
    chk("t3_rv_count", 32'(rv_count), 32'd2);

    // Bounce rejection, then exact press latency and single pulse.
    sw = 5'd5;
    press(1'b1, 1'b0, 8);
    chk("t4_led_a", 32'(state_led), 32'd1);
    led_changes = 0;
    for (int i = 0; i < 24; i++) begin
      btn_enter = (i < 2) || (i >= 4 && i < 6) || (i >= 8 && i < 11);
      tick();
      if (state_led !== 3'b001) led_changes++;
    end
    chk("t4_bounce_no_ent", 32'(led_changes), 32'd0);
    btn_enter = 1'b1;
    led_changes = 0;
    for (int i = 1; i <= DB + 3; i++) begin
      tick();
      if (state_led !== 3'b001) led_changes++;
    end
    chk("t4_no_early_ent", 32'(led_changes), 32'd0);
    tick();
    chk("t4_ent_latency", 32'(state_led), 32'd2);
    repeat (20 - (DB + 4)) tick();
    btn_enter = 1'b0;
    repeat (15) tick();
    chk("t4_single_ent", 32'(state_led), 32'd2);
    chk("t4_op_a", 32'(op_a), 32'd5);

    // Clear and enter coincide in LOAD_OP: clear wins.
    sw = 5'd9;
    press(1'b1, 1'b0, 8);
    chk("t5_led_op", 32'(state_led), 32'd4);
    chk("t5_op_b", 32'(op_b), 32'd9);
    sw_as = 1'b1;
    rv_snap = rv_count;
    press(1'b1, 1'b1, 8);
    sw_as = 1'b0;
    chk("t5_led_a", 32'(state_led), 32'd1);
    chk("t5_ops_zero", 32'({op_a, op_b, op_as}), 32'd0);
    chk("t5_res_zero", 32'({res_s, res_cout, res_ov, res_ready}), 32'd0);
    chk("t5_no_res_valid", 32'(rv_count), 32'(rv_snap));

    // -16 - 1 = +15: overflow, carry (no borrow).
    sw = 5'd16;
    press(1'b1, 1'b0, 8);
    sw = 5'd1;
    press(1'b1, 1'b0, 8);
    sw_as = 1'b1;
    sb_q.push_back('{s: 5'b01111, cout: 1'b1, ov: 1'b1});
    press(1'b1, 1'b0, 8);
    sw_as = 1'b0;
    chk("t6_ready", 32'(res_ready), 32'd1);
    sw = 5'd0;
    press(1'b1, 1'b0, 8);
    chk("t6_led_a", 32'(state_led), 32'd1);
    chk("t6_res_kept", 32'({res_s, res_cout, res_ov}), 32'({5'b01111, 1'b1, 1'b1}));
    chk("t6_ready_low", 32'(res_ready), 32'd0);
    chk("t6_op_a_kept", 32'(op_a), 32'd16);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("total_results", 32'(rv_count), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
